board_eval: RTL

Downstream consumer of the piece move generators (rook, knight, ...). Once a generator has written its candidate boards (64 signed bytes each) to SDRAM, software points this block at the same buffer. It reads every board over an Avalon master and computes a signed material score per board, white minus black. It writes one 32-bit score per board to a result array and tracks the best-scoring board.

---
 rtl/board_eval_if.sv | 31 +++
 rtl/board_eval.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/board_eval_if.sv
// Avalon-MM bundle for board_eval: the register slave plus the SDRAM read/write master.
// Modport slave is the block's own view; modport master is the host/memory side.
interface board_eval_if;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    modport slave (
        output slave_waitrequest, slave_readdata,
        input  slave_address, slave_read, slave_write, slave_writedata,
        input  master_waitrequest, master_readdata, master_readdatavalid,
        output master_address, master_read, master_write, master_writedata
    );

    modport master (
        input  slave_waitrequest, slave_readdata,
        output slave_address, slave_read, slave_write, slave_writedata,
        output master_waitrequest, master_readdata, master_readdatavalid,
        input  master_address, master_read, master_write, master_writedata
    );
endinterface

// File: rtl/board_eval.sv
// Material evaluator: reads 64-byte boards over Avalon, writes one signed score per board.
// Define BOARD_EVAL_ARGMAX_EN to track the best-scoring board in registers 4/5.
module board_eval #(
    parameter int P_VAL = 100,
    parameter int N_VAL = 320,
    parameter int B_VAL = 330,
    parameter int R_VAL = 500,
    parameter int Q_VAL = 900,
    parameter int K_VAL = 20000
) (
    input logic         clk,
    input logic         rst,
    board_eval_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    state_t             state;
    logic [31:0]        src_base, board_cnt, dst_base;
    logic [31:0]        rd_ptr, wr_ptr, board;
    logic [5:0]         square;
    logic signed [31:0] acc;
    logic               done, bad_code;
    logic               mst_read, mst_write;
    logic [31:0]        mst_address, mst_writedata, slv_readdata;
`ifdef BOARD_EVAL_ARGMAX_EN
    logic [31:0]        best_idx;
    logic signed [31:0] best_score;
`endif

    logic [7:0]         code, mag;
    logic signed [31:0] byte_val, acc_next;
    logic               byte_bad, start, reg0_stall;
    logic [31:0]        rd_mux;
    logic               unused_readdata_hi;

    assign unused_readdata_hi = ^bus.master_readdata[31:8];

    assign bus.master_read       = mst_read;
    assign bus.master_write      = mst_write;
    assign bus.master_address    = mst_address;
    assign bus.master_writedata  = mst_writedata;
    assign bus.slave_readdata    = slv_readdata;
    assign bus.slave_waitrequest = reg0_stall;

    assign code  = bus.master_readdata[7:0];
    // -128 has no positive twin; its 8-bit magnitude reads back as 128, which decodes as bad
    assign mag   = code[7] ? (~code + 8'd1) : code;
    assign start = bus.slave_write && (bus.slave_address == 4'd0) && (state == S_IDLE);
    assign reg0_stall = bus.slave_read && (bus.slave_address == 4'd0) && (state != S_IDLE);

    always_comb begin
        byte_bad = 1'b0;
        byte_val = '0;
        if (mag == 8'd0)       byte_val = '0;
        else if (mag <= 8'd8)  byte_val = 32'(P_VAL);
        else if (mag <= 8'd18) byte_val = 32'(R_VAL);
        else if (mag <= 8'd28) byte_val = 32'(N_VAL);
        else if (mag <= 8'd38) byte_val = 32'(B_VAL);
        else if (mag <= 8'd47) byte_val = 32'(Q_VAL);
        else if (mag == 8'd48) byte_val = 32'(K_VAL);
        else                   byte_bad = 1'b1;
        if (code[7]) byte_val = -byte_val;
        acc_next = acc + byte_val;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.slave_address)
            4'd0: rd_mux = {30'd0, bad_code, done};
            4'd1: rd_mux = src_base;
            4'd2: rd_mux = board_cnt;
            4'd3: rd_mux = dst_base;
`ifdef BOARD_EVAL_ARGMAX_EN
            4'd4: rd_mux = best_idx;
            4'd5: rd_mux = best_score;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            src_base      <= '0;
            board_cnt     <= '0;
            dst_base      <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            board         <= '0;
            square        <= '0;
            acc           <= '0;
            done          <= 1'b0;
            bad_code      <= 1'b0;
            mst_read      <= 1'b0;
            mst_write     <= 1'b0;
            mst_address   <= '0;
            mst_writedata <= '0;
            slv_readdata  <= '0;
`ifdef BOARD_EVAL_ARGMAX_EN
            best_idx      <= '0;
            best_score    <= '0;
`endif
        end else begin
            if (bus.slave_read && !reg0_stall)
                slv_readdata <= rd_mux;

            if (bus.slave_write && state == S_IDLE) begin
                case (bus.slave_address)
                    4'd1: src_base  <= bus.slave_writedata;
                    4'd2: board_cnt <= bus.slave_writedata;
                    4'd3: dst_base  <= bus.slave_writedata;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        done     <= 1'b0;
                        bad_code <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    acc      <= '0;
                    square   <= '0;
                    board    <= '0;
                    bad_code <= 1'b0;
                    rd_ptr   <= src_base;
                    wr_ptr   <= dst_base;
`ifdef BOARD_EVAL_ARGMAX_EN
                    best_idx   <= '1;
                    best_score <= {1'b1, 31'd0};
`endif
                    if (board_cnt == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state       <= S_RD;
                        mst_read    <= 1'b1;
                        mst_address <= src_base;
                    end
                end
                S_RD: begin
                    if (!bus.master_waitrequest) begin
                        mst_read <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.master_readdatavalid) begin
                        acc    <= acc_next;
                        rd_ptr <= rd_ptr + 32'd1;
                        if (byte_bad) bad_code <= 1'b1;
                        if (square == 6'd63) begin
                            state         <= S_WR;
                            mst_write     <= 1'b1;
                            mst_address   <= wr_ptr;
                            mst_writedata <= acc_next;
                        end else begin
                            square      <= square + 6'd1;
                            state       <= S_RD;
                            mst_read    <= 1'b1;
                            mst_address <= rd_ptr + 32'd1;
                        end
                    end
                end
                S_WR: begin
                    if (!bus.master_waitrequest) begin
                        mst_write <= 1'b0;
                        board     <= board + 32'd1;
                        acc       <= '0;
                        square    <= '0;
                        wr_ptr    <= wr_ptr + 32'd4;
`ifdef BOARD_EVAL_ARGMAX_EN
                        // strict compare: on a tie the earlier board keeps the title
                        if (acc > best_score) begin
                            best_idx   <= board;
                            best_score <= acc;
                        end
`endif
                        if (board == board_cnt - 32'd1) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= S_RD;
                            mst_read    <= 1'b1;
                            mst_address <= rd_ptr;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
